// File: rtl/fpmul_pkg.sv
// Shared FPmul definitions: IEEE-754 single field positions, default pipeline
// latency and the result-checker state encoding.
package fpmul_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;
  localparam int MAN_LSB  = 0;
  localparam logic [7:0] EXP_ALL1 = 8'hFF;

  localparam int FPMUL_LATENCY = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_e;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[EXP_MSB:EXP_LSB] == EXP_ALL1) && (v[MAN_MSB:MAN_LSB] != '0);
  endfunction

endpackage

// File: rtl/fpmul_result_checker_if.sv
// Stream/status bundle between the FPmul harness (master) and the result checker (slave).
interface fpmul_result_checker_if #(
  parameter int CNT_W = 16
);
  logic             VIN;
  logic [31:0]      EXP_i;
  logic [31:0]      DIN;
  logic             END_SIM;
  logic [CNT_W-1:0] PASS_CNT;
  logic [CNT_W-1:0] FAIL_CNT;
  logic [CNT_W-1:0] FIRST_ERR_IDX;
  logic [31:0]      FIRST_ERR_VAL;
  logic             ERR;
  logic             DONE;

  modport master (
    output VIN, EXP_i, DIN, END_SIM,
    input  PASS_CNT, FAIL_CNT, FIRST_ERR_IDX, FIRST_ERR_VAL, ERR, DONE
  );

  modport slave (
    input  VIN, EXP_i, DIN, END_SIM,
    output PASS_CNT, FAIL_CNT, FIRST_ERR_IDX, FIRST_ERR_VAL, ERR, DONE
  );
endinterface

// File: rtl/fp_tol_compare.sv
// Combinational single-precision comparator: NaN-equivalence, signed-zero
// equivalence, otherwise same-sign magnitude distance within TOL_ULP.
module fp_tol_compare
  import fpmul_pkg::*;
#(
  parameter int TOL_ULP = 0
) (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        pass
);
  localparam logic [31:0] TOL = 32'(TOL_ULP);

  logic [30:0] mag_a, mag_b, diff;
  logic        a_nan, b_nan;

  always_comb begin
    mag_a = a[SIGN_BIT-1:0];
    mag_b = b[SIGN_BIT-1:0];
    diff  = (mag_a >= mag_b) ? (mag_a - mag_b) : (mag_b - mag_a);
    a_nan = is_nan(a);
    b_nan = is_nan(b);
    pass  = 1'b0;
    if (a == b)
      pass = 1'b1;
    else if (a_nan || b_nan)
      pass = a_nan && b_nan;
    else if (a[SIGN_BIT] != b[SIGN_BIT])
      pass = (mag_a == '0) && (mag_b == '0);
    else
      // ordered magnitudes make Inf vs max-finite a plain 1-ULP step
      pass = ({1'b0, diff} <= TOL);
  end
endmodule

// File: rtl/fpmul_result_checker.sv
// Output-side FPmul checker: carries each golden product down a LATENCY-deep
// delay line, compares it with FP_Z and keeps saturating pass/fail statistics.
module fpmul_result_checker
  import fpmul_pkg::*;
#(
  parameter int LATENCY = FPMUL_LATENCY,
  parameter int TOL_ULP = 0,
  parameter int CNT_W   = 16
) (
  input logic                   CLK,
  input logic                   RST_n,
  fpmul_result_checker_if.slave chk
);
  localparam int               DW         = 5;
  localparam logic [DW-1:0]    DRAIN_LOAD = DW'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  chk_state_e               state_q, state_d;
  logic [DW-1:0]            drain_q, drain_d;
  logic [LATENCY-1:0]       vld_pipe_q, vld_pipe_d;
  logic [LATENCY-1:0][31:0] exp_pipe_q, exp_pipe_d;
  logic [CNT_W-1:0]         pass_q, pass_d;
  logic [CNT_W-1:0]         fail_q, fail_d;
  logic [CNT_W-1:0]         idx_q, idx_d;
  logic [31:0]              errval_q, errval_d;
  logic                     err_q, err_d;

  logic             accept, cmp_en, cmp_pass;
  logic [CNT_W:0]   total;
  logic [CNT_W-1:0] res_idx;

  fp_tol_compare #(.TOL_ULP(TOL_ULP)) u_cmp (
    .a    (chk.DIN),
    .b    (exp_pipe_q[LATENCY-1]),
    .pass (cmp_pass)
  );

  // new issues enter the line only before drain starts
  assign accept  = chk.VIN && ((state_q == ST_IDLE) || (state_q == ST_RUN));
  assign cmp_en  = vld_pipe_q[LATENCY-1] && (state_q != ST_DONE);
  assign total   = {1'b0, pass_q} + {1'b0, fail_q};
  assign res_idx = total[CNT_W] ? CNT_MAX : total[CNT_W-1:0];

  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    exp_pipe_d    = exp_pipe_q;
    vld_pipe_d[0] = accept;
    exp_pipe_d[0] = chk.EXP_i;
    for (int i = 1; i < LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      exp_pipe_d[i] = exp_pipe_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (chk.END_SIM) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (chk.VIN) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (chk.END_SIM) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        // DONE registers on the edge the count hits 0, together with the last compare's update
        drain_d = drain_q - 1'b1;
        if (drain_q <= DW'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pass_d   = pass_q;
    fail_d   = fail_q;
    idx_d    = idx_q;
    errval_d = errval_q;
    err_d    = err_q;
    if (cmp_en) begin
      if (cmp_pass) begin
        if (pass_q != CNT_MAX) pass_d = pass_q + 1'b1;
      end else begin
        if (fail_q != CNT_MAX) fail_d = fail_q + 1'b1;
        if (!err_q) begin
          err_d    = 1'b1;
          idx_d    = res_idx;
          errval_d = chk.DIN;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= ST_IDLE;
      drain_q    <= '0;
      vld_pipe_q <= '0;
      exp_pipe_q <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      idx_q      <= '0;
      errval_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      vld_pipe_q <= vld_pipe_d;
      exp_pipe_q <= exp_pipe_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      idx_q      <= idx_d;
      errval_q   <= errval_d;
      err_q      <= err_d;
    end
  end

  assign chk.PASS_CNT      = pass_q;
  assign chk.FAIL_CNT      = fail_q;
  assign chk.FIRST_ERR_IDX = idx_q;
  assign chk.FIRST_ERR_VAL = errval_q;
  assign chk.ERR           = err_q;
  assign chk.DONE          = (state_q == ST_DONE);
endmodule

// File: tb/tb_fpmul_result_checker.sv
// Bench for fpmul_result_checker: three instances (exact, 1-ULP tolerance,
// 4-bit counters) share one stimulus stream; table vectors, directed runs, random runs.
module tb_fpmul_result_checker;
  import fpmul_pkg::*;

  localparam int LAT  = FPMUL_LATENCY;
  localparam int MAXN = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        vin = 1'b0, end_sim = 1'b0;
  logic [31:0] exp_i = '0, din = '0;
  int          n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  fpmul_result_checker_if #(.CNT_W(16)) if0 ();
  fpmul_result_checker_if #(.CNT_W(16)) if1 ();
  fpmul_result_checker_if #(.CNT_W(4))  if2 ();

  assign if0.VIN = vin; assign if0.EXP_i = exp_i; assign if0.DIN = din; assign if0.END_SIM = end_sim;
  assign if1.VIN = vin; assign if1.EXP_i = exp_i; assign if1.DIN = din; assign if1.END_SIM = end_sim;
  assign if2.VIN = vin; assign if2.EXP_i = exp_i; assign if2.DIN = din; assign if2.END_SIM = end_sim;

  fpmul_result_checker #(.LATENCY(LAT), .TOL_ULP(0), .CNT_W(16)) dut0 (.CLK(clk), .RST_n(rst_n), .chk(if0));
  fpmul_result_checker #(.LATENCY(LAT), .TOL_ULP(1), .CNT_W(16)) dut1 (.CLK(clk), .RST_n(rst_n), .chk(if1));
  fpmul_result_checker #(.LATENCY(LAT), .TOL_ULP(0), .CNT_W(4))  dut2 (.CLK(clk), .RST_n(rst_n), .chk(if2));

  // per-cycle stimulus plan: issue flag, golden product, FP_Z to return for it, END_SIM
  bit          vin_a [MAXN];
  bit          end_a [MAXN];
  logic [31:0] exp_a [MAXN];
  logic [31:0] dout_a[MAXN];

  typedef struct {
    string       name;
    logic [31:0] e;
    logic [31:0] z;
    bit          p0;
    bit          p1;
  } vec_t;
  vec_t vq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic add_vec(input string n, input logic [31:0] e, input logic [31:0] z, input bit p0, input bit p1);
    vec_t v;
    v.name = n; v.e = e; v.z = z; v.p0 = p0; v.p1 = p1;
    vq.push_back(v);
  endtask

  task automatic clear_plan();
    for (int i = 0; i < MAXN; i++) begin
      vin_a[i] = 0; end_a[i] = 0; exp_a[i] = '0; dout_a[i] = '0;
    end
  endtask

  task automatic do_reset();
    vin = 0; end_sim = 0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drives ncyc cycles from the plan; DIN returns an issue's product LAT cycles later, junk otherwise.
  task automatic play(input int len, input int ncyc, output int done_edge);
    done_edge = -1;
    for (int c = 0; c < ncyc; c++) begin
      vin = 0; end_sim = 0; exp_i = $urandom; din = $urandom;
      if (c < len) begin
        vin = vin_a[c]; end_sim = end_a[c]; exp_i = exp_a[c];
      end
      if (c >= LAT && (c - LAT) < len) begin
        if (vin_a[c-LAT]) din = dout_a[c-LAT];
      end
      @(posedge clk); #1;
      if (done_edge < 0 && if0.DONE) done_edge = c;
    end
    vin = 0; end_sim = 0;
  endtask

  function automatic bit ref_pass(input logic [31:0] z, input logic [31:0] e, input int tol);
    bit    zn, en;
    longint mz, me, d;
    zn = (z[30:23] == 8'hFF) && (z[22:0] != 0);
    en = (e[30:23] == 8'hFF) && (e[22:0] != 0);
    mz = longint'(z[30:0]);
    me = longint'(e[30:0]);
    d  = (mz > me) ? mz - me : me - mz;
    if (z == e) return 1'b1;
    if (zn || en) return zn && en;
    if (z[31] != e[31]) return (mz == 0) && (me == 0);
    return d <= longint'(tol);
  endfunction

  // Expected end-of-run statistics straight from the issue list.
  task automatic model(input int len, input int tol, input int cw, output int p, output int f,
                       output int fidx, output logic [31:0] fval, output bit err, output int endc);
    int sat, idx;
    sat = (1 << cw) - 1;
    p = 0; f = 0; fidx = 0; fval = '0; err = 0; endc = -1;
    for (int c = 0; c < len; c++) begin
      if (vin_a[c]) begin
        idx = (p + f > sat) ? sat : p + f;
        if (ref_pass(dout_a[c], exp_a[c], tol)) begin
          if (p < sat) p++;
        end else begin
          if (!err) begin err = 1; fidx = idx; fval = dout_a[c]; end
          if (f < sat) f++;
        end
      end
      if (end_a[c]) begin endc = c; break; end
    end
  endtask

  task automatic check_res(input string tag, input int d, input int p, input int f, input int fidx,
                           input logic [31:0] fval, input bit err);
    logic [63:0] ap, af, ai, av, ae;
    case (d)
      0:       begin ap = 64'(if0.PASS_CNT); af = 64'(if0.FAIL_CNT); ai = 64'(if0.FIRST_ERR_IDX); av = 64'(if0.FIRST_ERR_VAL); ae = 64'(if0.ERR); end
      1:       begin ap = 64'(if1.PASS_CNT); af = 64'(if1.FAIL_CNT); ai = 64'(if1.FIRST_ERR_IDX); av = 64'(if1.FIRST_ERR_VAL); ae = 64'(if1.ERR); end
      default: begin ap = 64'(if2.PASS_CNT); af = 64'(if2.FAIL_CNT); ai = 64'(if2.FIRST_ERR_IDX); av = 64'(if2.FIRST_ERR_VAL); ae = 64'(if2.ERR); end
    endcase
    check($sformatf("%s.d%0d.pass", tag, d), ap, 64'(p));
    check($sformatf("%s.d%0d.fail", tag, d), af, 64'(f));
    check($sformatf("%s.d%0d.idx",  tag, d), ai, 64'(fidx));
    check($sformatf("%s.d%0d.val",  tag, d), av, 64'(fval));
    check($sformatf("%s.d%0d.err",  tag, d), ae, 64'(err));
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] sp[8];
    sp = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'h7F7FFFFF,
           32'h7FC00000, 32'hFF800000, 32'h3F800000, 32'h00000001};
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return sp[$urandom_range(0, 7)];
      default: return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  function automatic logic [31:0] perturb(input logic [31:0] e);
    logic [31:0] z;
    z = e;
    case ($urandom_range(0, 5))
      0, 1: z = e;
      2:    if (e[30:0] != 31'h7FFFFFFF) z = e + 32'd1;
      3:    if (e[30:0] != 31'h0) z = e - 32'd1;
      4:    z = e ^ (32'h1 << $urandom_range(0, 31));
      default: z = {1'($urandom), 8'hFF, 23'($urandom_range(1, 8388607))};
    endcase
    return z;
  endfunction

  task automatic random_run(input int r);
    int len, endc, de, p, f, fi, ec;
    logic [31:0] fv;
    bit e;
    clear_plan();
    len  = $urandom_range(4, 40);
    endc = $urandom_range(0, len - 1);
    for (int c = 0; c < len; c++) begin
      vin_a[c]  = ($urandom_range(0, 3) != 0);
      exp_a[c]  = rand_fp();
      dout_a[c] = perturb(exp_a[c]);
    end
    end_a[endc] = 1;
    if ($urandom_range(0, 1) == 1)
      for (int c = endc; c < len; c++) end_a[c] = 1;
    do_reset();
    play(len, len + LAT + 4, de);
    model(len, 0, 16, p, f, fi, fv, e, ec);
    check_res($sformatf("rnd%0d", r), 0, p, f, fi, fv, e);
    check($sformatf("rnd%0d.done_edge", r), 64'(de), 64'(ec + LAT));
    model(len, 1, 16, p, f, fi, fv, e, ec);
    check_res($sformatf("rnd%0d", r), 1, p, f, fi, fv, e);
    model(len, 0, 4, p, f, fi, fv, e, ec);
    check_res($sformatf("rnd%0d", r), 2, p, f, fi, fv, e);
    check($sformatf("rnd%0d.d2.done", r), 64'(if2.DONE), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int de;
    logic [31:0] corrupt;

    // reset state
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst.pass", 64'(if0.PASS_CNT), 0);
    check("rst.fail", 64'(if0.FAIL_CNT), 0);
    check("rst.idx",  64'(if0.FIRST_ERR_IDX), 0);
    check("rst.val",  64'(if0.FIRST_ERR_VAL), 0);
    check("rst.err",  64'(if0.ERR), 0);
    check("rst.done", 64'(if0.DONE), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single-result special-value table: {EXP, DIN, pass@TOL0, pass@TOL1}
    add_vec("exact",        32'h3F800000, 32'h3F800000, 1, 1);
    add_vec("nan_payload",  32'h7FC00000, 32'h7FC00001, 1, 1);
    add_vec("zero_sign",    32'h00000000, 32'h80000000, 1, 1);
    add_vec("sign_one",     32'h3F800000, 32'hBF800000, 0, 0);
    add_vec("lsb_flip",     32'h3F800000, 32'h3F800001, 0, 1);
    add_vec("inf_vs_max",   32'h7F800000, 32'h7F7FFFFF, 0, 1);
    add_vec("nan_vs_inf",   32'h7F800000, 32'h7F800001, 0, 0);
    add_vec("snan_qnan",    32'h7F800001, 32'hFFC00000, 1, 1);
    add_vec("two_ulp",      32'h3F800000, 32'h3F800002, 0, 0);
    add_vec("neg_ulp",      32'hBF800001, 32'hBF800000, 0, 1);
    add_vec("denorm_sign",  32'h00000001, 32'h80000001, 0, 0);
    add_vec("denorm_zero",  32'h00000001, 32'h00000000, 0, 1);
    foreach (vq[k]) begin
      clear_plan();
      vin_a[0] = 1; end_a[0] = 1; exp_a[0] = vq[k].e; dout_a[0] = vq[k].z;
      do_reset();
      play(1, LAT + 4, de);
      check({vq[k].name, ".t0.pass"}, 64'(if0.PASS_CNT), 64'(vq[k].p0));
      check({vq[k].name, ".t0.fail"}, 64'(if0.FAIL_CNT), 64'(!vq[k].p0));
      check({vq[k].name, ".t0.err"},  64'(if0.ERR),      64'(!vq[k].p0));
      check({vq[k].name, ".t1.pass"}, 64'(if1.PASS_CNT), 64'(vq[k].p1));
      check({vq[k].name, ".t1.fail"}, 64'(if1.FAIL_CNT), 64'(!vq[k].p1));
    end

    // exact stream of 10, END_SIM with the last issue
    clear_plan();
    for (int c = 0; c < 10; c++) begin
      vin_a[c] = 1;
      exp_a[c] = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      dout_a[c] = exp_a[c];
    end
    end_a[9] = 1;
    do_reset();
    play(10, 10 + LAT + 4, de);
    check_res("exact10", 0, 10, 0, 0, 32'h0, 0);
    check("exact10.done_edge", 64'(de), 64'(9 + LAT));

    // result 3 corrupted by one LSB
    corrupt   = exp_a[3] ^ 32'h1;
    dout_a[3] = corrupt;
    do_reset();
    play(10, 10 + LAT + 4, de);
    check_res("corrupt", 0, 9, 1, 3, corrupt, 1);
    check_res("corrupt", 1, 10, 0, 0, 32'h0, 0);

    // bubbles 1,0,1,1,0 with END_SIM on the last issue; bubble DIN is junk
    clear_plan();
    vin_a[0] = 1; vin_a[2] = 1; vin_a[3] = 1; end_a[3] = 1;
    for (int c = 0; c < 5; c++) begin exp_a[c] = 32'h40000000 + 32'(c); dout_a[c] = exp_a[c]; end
    do_reset();
    play(5, 5 + LAT + 4, de);
    check_res("bubble", 0, 3, 0, 0, 32'h0, 0);
    check("bubble.done_edge", 64'(de), 64'(3 + LAT));

    // issues after END_SIM are not accepted (their DIN would fail)
    clear_plan();
    for (int c = 0; c < 5; c++) begin vin_a[c] = 1; exp_a[c] = 32'h41000000 + 32'(c); dout_a[c] = ~exp_a[c]; end
    dout_a[0] = exp_a[0]; dout_a[1] = exp_a[1]; end_a[1] = 1;
    do_reset();
    play(5, 5 + LAT + 4, de);
    check_res("post_end", 0, 2, 0, 0, 32'h0, 0);

    // saturation: 20 passing results
    clear_plan();
    for (int c = 0; c < 20; c++) begin vin_a[c] = 1; exp_a[c] = 32'h3F000000 + 32'(c); dout_a[c] = exp_a[c]; end
    end_a[19] = 1;
    do_reset();
    play(20, 20 + LAT + 4, de);
    check_res("sat", 2, 15, 0, 0, 32'h0, 0);
    check_res("sat", 0, 20, 0, 0, 32'h0, 0);
    check("sat.d2.done", 64'(if2.DONE), 1);

    // async reset in the middle of DRAIN discards the in-flight results
    do_reset();
    play(20, 22, de);
    check("mid.d0.pass", 64'(if0.PASS_CNT), 18);
    check("mid.d2.pass", 64'(if2.PASS_CNT), 15);
    check("mid.d0.done", 64'(if0.DONE), 0);
    #3 rst_n = 1'b0;
    #1;
    check("arst.d0.pass", 64'(if0.PASS_CNT), 0);
    check("arst.d2.pass", 64'(if2.PASS_CNT), 0);
    check("arst.d0.done", 64'(if0.DONE), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_plan();
    play(0, LAT + 4, de);
    check("arst.idle.pass", 64'(if0.PASS_CNT), 0);
    check("arst.idle.done", 64'(if0.DONE), 0);

    // empty run
    clear_plan();
    end_a[0] = 1;
    do_reset();
    play(1, LAT + 4, de);
    check_res("empty", 0, 0, 0, 0, 32'h0, 0);
    check("empty.done_edge", 64'(de), 64'(LAT));

    for (int r = 0; r < 30; r++) random_run(r);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
